// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a registered carry.
// Latency: start sampled at edge k, result and done visible after edge k+WIDTH/DIGIT.
// Backpressure: none; start is ignored while busy and accepted again in the done cycle.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject geometries that cannot be split into whole digits.
  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_geometry
      $error("serial_add_sub: WIDTH must be >= 1 and an integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dig;
  logic             msb_cin;
  logic             accept;
  logic             last;

  // One digit of addition plus the carry into the top bit of that digit.
  always_comb begin
    dig     = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Sum bit = a ^ b ^ carry-in, so the carry into the digit MSB is recovered from it;
    // on the last digit this is the carry into bit WIDTH-1.
    msb_cin = dig[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
    acc_nxt = (acc >> DIGIT) | (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT));
    accept  = start && (state == IDLE || state == DONE);
    last    = (state == RUN) && (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; busy and done are mutually exclusive by state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit shifting, and result update on the final digit only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> DIGIT;
      opb   <= opb >> DIGIT;
      carry <= dig[DIGIT];
      cnt   <= cnt + 1'b1;
      acc   <= acc_nxt;
      if (last) begin
        sum  <= acc_nxt;
        cout <= dig[DIGIT];
        ovf  <= msb_cin ^ dig[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: 8-bit/1-bit-digit and 16-bit/4-bit-digit instances
// driven by directed and random operations, checked against an arithmetic model.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st;
  logic        sel;
  logic        sub, cin;
  logic [15:0] a, b;

  logic        start8, start16;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic        obs_busy, obs_done;
  logic [17:0] obs_res;

  logic [17:0] last_res [2];
  int          ntests = 0;
  int          nfail  = 0;

  always #5 clk = ~clk;

  assign start8  = st & ~sel;
  assign start16 = st & sel;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .cin(cin),
    .a(a[7:0]), .b(b[7:0]), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy16), .done(done16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  always_comb begin
    obs_busy = sel ? busy16 : busy8;
    obs_done = sel ? done16 : done8;
    obs_res  = sel ? {ovf16, cout16, sum16} : {ovf8, cout8, 8'h00, sum8};
  end

  // Reference: plain modular arithmetic; ovf = operands same sign, result differs.
  function automatic logic [17:0] model(input int w, input logic [15:0] ia, ib,
                                        input logic isub, icin);
    logic [31:0] m, aa, bb, full, s;
    logic        co, ov;
    m    = (32'd1 << w) - 32'd1;
    aa   = {16'h0, ia} & m;
    bb   = (isub ? ~{16'h0, ib} : {16'h0, ib}) & m;
    full = aa + bb + (isub ? 32'd1 : {31'd0, icin});
    s    = full & m;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, co, s[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    a   = 16'($urandom);
    b   = 16'($urandom);
    sub = 1'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic do_op(input logic s, input logic [15:0] ia, ib,
                       input logic isub, icin, input bit glitch);
    logic [17:0] exp;
    int          n, lat;
    sel = s;
    a = ia; b = ib; sub = isub; cin = icin; st = 1'b1;
    n   = s ? 4 : 8;
    exp = model(s ? 16 : 8, ia, ib, isub, icin);
    step();
    st = 1'b0;
    rand_inputs();
    chk("busy_after_start", 32'(obs_busy), 32'd1);
    chk("done_after_start", 32'(obs_done), 32'd0);
    chk("sum_held_in_run", 32'(obs_res), 32'(last_res[s]));
    lat = 0;
    while (!obs_done && lat < n + 4) begin
      if (glitch && lat == 2) begin
        st = 1'b1;
        rand_inputs();
      end else begin
        st = 1'b0;
      end
      step();
      lat++;
    end
    st = 1'b0;
    chk("latency", 32'(lat), 32'(n));
    chk("done_pulse", 32'(obs_done), 32'd1);
    chk("busy_in_done", 32'(obs_busy), 32'd0);
    chk("result", 32'(obs_res), 32'(exp));
    last_res[s] = exp;
    if (glitch) begin
      repeat (n + 2) begin
        step();
        chk("no_extra_done", 32'(obs_done), 32'd0);
        chk("no_extra_busy", 32'(obs_busy), 32'd0);
      end
      chk("result_after_glitch", 32'(obs_res), 32'(exp));
    end else begin
      step();
      chk("done_one_cycle", 32'(obs_done), 32'd0);
      chk("idle_after_done", 32'(obs_busy), 32'd0);
    end
  endtask

  initial begin
    logic [17:0] r1, r2;
    int          lat;
    rst_n = 1'b0; st = 1'b0; sel = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    last_res[0] = '0;
    last_res[1] = '0;

    // Reset values on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_busy", 32'(obs_busy), 32'd0);
      chk("rst_done", 32'(obs_done), 32'd0);
      chk("rst_result", 32'(obs_res), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Directed 8-bit cases.
    do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 16'h007F, 16'h0001, 1'b0, 1'b1, 1'b0);
    do_op(1'b0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    do_op(1'b0, 16'h0080, 16'h0001, 1'b1, 1'b0, 1'b0);
    // Start pulsed mid-run must be ignored.
    do_op(1'b0, 16'h0033, 16'h0044, 1'b0, 1'b1, 1'b1);

    // Back-to-back: start held through the done cycle.
    sel = 1'b0;
    r1 = model(8, 16'h0012, 16'h0034, 1'b0, 1'b0);
    r2 = model(8, 16'h00C8, 16'h0064, 1'b1, 1'b0);
    a = 16'h0012; b = 16'h0034; sub = 1'b0; cin = 1'b0; st = 1'b1;
    step();
    a = 16'h00C8; b = 16'h0064; sub = 1'b1;
    lat = 0;
    while (!obs_done && lat < 12) begin
      step();
      lat++;
    end
    chk("b2b_first_latency", 32'(lat), 32'd8);
    chk("b2b_first_result", 32'(obs_res), 32'(r1));
    step();
    st = 1'b0;
    rand_inputs();
    chk("b2b_restart_busy", 32'(obs_busy), 32'd1);
    chk("b2b_restart_done", 32'(obs_done), 32'd0);
    chk("b2b_sum_held", 32'(obs_res), 32'(r1));
    lat = 1;
    while (!obs_done && lat < 14) begin
      step();
      lat++;
    end
    chk("b2b_second_gap", 32'(lat), 32'd9);
    chk("b2b_second_result", 32'(obs_res), 32'(r2));
    last_res[0] = r2;
    step();
    chk("b2b_done_one_cycle", 32'(obs_done), 32'd0);

    // Random 8-bit operations.
    for (int i = 0; i < 20; i++)
      do_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // 16-bit, 4-bit digits.
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      do_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // Asynchronous reset mid-run aborts with no done pulse.
    sel = 1'b0;
    a = 16'h0011; b = 16'h0022; sub = 1'b0; cin = 1'b0; st = 1'b1;
    step();
    st = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(obs_busy), 32'd0);
    chk("arst_done", 32'(obs_done), 32'd0);
    chk("arst_result", 32'(obs_res), 32'd0);
    last_res[0] = '0;
    last_res[1] = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) begin
      step();
      chk("arst_no_done", 32'(obs_done), 32'd0);
    end
    do_op(1'b0, 16'h0040, 16'h0040, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
